// File: rtl/mpy_pkg.sv
// Shared definitions for the multiplier accumulate path: FSM states,
// widths and the 64-bit output clamp.
package mpy_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int PROD_W        = 64;
    localparam int ACC_W_DEF     = 72;
    localparam int MAX_TERMS_DEF = 256;
    localparam int CNT_W_DEF     = 9;

    // Widest accumulator the clamp helper accepts; narrower accumulators are
    // sign-extended to this width before clamping.
    localparam int SAT_IN_W = 128;

    localparam logic signed [PROD_W-1:0] SUM_MAX = 64'sh7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [PROD_W-1:0] SUM_MIN = 64'sh8000_0000_0000_0000;

    // Returns {ovf, sum}. The value fits in 64 bits exactly when bit 63 and
    // every bit above it agree; otherwise clamp toward the sign.
    function automatic logic [PROD_W:0] sat64(input logic signed [SAT_IN_W-1:0] a);
        logic [SAT_IN_W-PROD_W:0] hi;
        hi = a[SAT_IN_W-1:PROD_W-1];
        if ((&hi) || !(|hi)) begin
            sat64 = {1'b0, a[PROD_W-1:0]};
        end else if (a[SAT_IN_W-1]) begin
            sat64 = {1'b1, SUM_MIN};
        end else begin
            sat64 = {1'b1, SUM_MAX};
        end
    endfunction

endpackage

// File: rtl/mpy_sat.sv
// Combinational clamp of a signed ACC_W-bit accumulator to signed 64 bits,
// with a flag telling whether clamping occurred.
module mpy_sat
    import mpy_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic signed [ACC_W-1:0]  acc,
    output logic signed [PROD_W-1:0] sum,
    output logic                     ovf
);

    logic signed [SAT_IN_W-1:0] wide;
    logic [PROD_W:0]            res;

    // Sign-extend to the helper width, then clamp.
    always_comb begin
        wide = SAT_IN_W'(acc);
        res  = sat64(wide);
        ovf  = res[PROD_W];
        sum  = res[PROD_W-1:0];
    end

endmodule

// File: rtl/mpy_accum.sv
// Burst accumulator behind the Booth multiplier: sums signed 64-bit products
// in a guard-bit accumulator and presents a clamped 64-bit result with
// overflow / truncation flags, held until the downstream accepts it.
module mpy_accum
    import mpy_pkg::*;
#(
    parameter int ACC_W     = ACC_W_DEF,
    parameter int MAX_TERMS = MAX_TERMS_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [PROD_W-1:0] in_prod,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [PROD_W-1:0] out_sum,
    output logic                     out_ovf,
    output logic                     out_trunc,
    output logic [CNT_W-1:0]         out_cnt
);

    state_t                   state;
    state_t                   state_nxt;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_sum;
    logic [CNT_W-1:0]         cnt;
    logic [CNT_W-1:0]         cnt_inc;
    logic                     in_fire;
    logic                     out_fire;
    logic                     hit_max;
    logic                     burst_end;
    logic signed [PROD_W-1:0] sat_sum;
    logic                     sat_ovf;

    // A held result frees the input only when it retires in the same cycle;
    // clr blocks acceptance outright.
    assign in_ready  = !clr && ((state != HOLD) || out_ready);
    assign out_valid = (state == HOLD);

    // Next accumulator/count: a burst continues only from ACC, any other
    // state starts afresh from the incoming product.
    always_comb begin
        in_fire  = in_valid && in_ready;
        out_fire = out_valid && out_ready;
        if (state == ACC) begin
            acc_sum = acc + ACC_W'(in_prod);
            cnt_inc = cnt + CNT_W'(1);
        end else begin
            acc_sum = ACC_W'(in_prod);
            cnt_inc = CNT_W'(1);
        end
        hit_max   = (cnt_inc == CNT_W'(MAX_TERMS));
        burst_end = in_last || hit_max;
    end

    // Clamp the sum that includes the term being accepted, so the result is
    // ready on the same edge that closes the burst.
    mpy_sat #(
        .ACC_W (ACC_W)
    ) u_sat (
        .acc (acc_sum),
        .sum (sat_sum),
        .ovf (sat_ovf)
    );

    // Next-state logic; clr outranks every handshake.
    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = IDLE;
        end else if (in_fire) begin
            state_nxt = burst_end ? HOLD : ACC;
        end else if (out_fire) begin
            state_nxt = IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Accumulator, term counter and the held result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            cnt       <= '0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
            out_trunc <= 1'b0;
            out_cnt   <= '0;
        end else if (clr) begin
            acc <= '0;
            cnt <= '0;
        end else if (in_fire) begin
            acc <= acc_sum;
            cnt <= cnt_inc;
            if (burst_end) begin
                out_sum   <= sat_sum;
                out_ovf   <= sat_ovf;
                out_trunc <= !in_last;
                out_cnt   <= cnt_inc;
            end
        end
    end

endmodule

// File: tb/tb_mpy_accum.sv
// Directed bench for mpy_accum with a queue-based reference model checked
// on every falling edge, plus literal expectations per scenario.
module tb_mpy_accum;

    localparam int ACC_W     = 72;
    localparam int MAX_TERMS = 256;
    localparam int CNT_W     = 9;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b1;
    logic             clr       = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_last   = 1'b0;
    logic             out_ready = 1'b0;
    logic [63:0]      in_prod   = 64'd0;
    logic             in_ready;
    logic             out_valid;
    logic             out_ovf;
    logic             out_trunc;
    logic [63:0]      out_sum;
    logic [CNT_W-1:0] out_cnt;

    int checks   = 0;
    int failures = 0;

    mpy_accum #(
        .ACC_W     (ACC_W),
        .MAX_TERMS (MAX_TERMS),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .out_trunc (out_trunc),
        .out_cnt   (out_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: terms of the open burst in a queue, summed in wide
    // arithmetic when the burst closes.
    longint             q[$];
    logic               m_valid = 1'b0;
    logic [63:0]        m_sum   = 64'd0;
    logic               m_ovf   = 1'b0;
    logic               m_trunc = 1'b0;
    int                 m_cnt   = 0;
    logic               m_rdy, m_inf, m_outf;
    logic signed [127:0] m_s;
    logic signed [127:0] lim_hi = 128'sh7FFF_FFFF_FFFF_FFFF;
    logic signed [127:0] lim_lo = -128'sh8000_0000_0000_0000;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_valid = 1'b0;
        end else if (clr) begin
            q.delete();
            m_valid = 1'b0;
        end else begin
            m_rdy  = !m_valid || out_ready;
            m_inf  = in_valid && m_rdy;
            m_outf = m_valid && out_ready;
            if (m_outf) m_valid = 1'b0;
            if (m_inf) begin
                q.push_back(longint'(in_prod));
                if (in_last || q.size() == MAX_TERMS) begin
                    m_s = 128'sd0;
                    foreach (q[i]) m_s = m_s + q[i];
                    if (m_s > lim_hi) begin
                        m_sum = 64'h7FFF_FFFF_FFFF_FFFF;
                        m_ovf = 1'b1;
                    end else if (m_s < lim_lo) begin
                        m_sum = 64'h8000_0000_0000_0000;
                        m_ovf = 1'b1;
                    end else begin
                        m_sum = m_s[63:0];
                        m_ovf = 1'b0;
                    end
                    m_trunc = !in_last;
                    m_cnt   = q.size();
                    q.delete();
                    m_valid = 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_out_sum", out_sum, 64'd0);
            chk("rst_out_cnt", 64'(out_cnt), 64'd0);
        end else begin
            chk("in_ready", 64'(in_ready), 64'(!clr && (!m_valid || out_ready)));
            chk("out_valid", 64'(out_valid), 64'(m_valid));
            if (m_valid) begin
                chk("out_sum", out_sum, m_sum);
                chk("out_ovf", 64'(out_ovf), 64'(m_ovf));
                chk("out_trunc", 64'(out_trunc), 64'(m_trunc));
                chk("out_cnt", 64'(out_cnt), 64'(m_cnt));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] p, input logic last);
        logic took;
        took     = 1'b0;
        in_valid = 1'b1;
        in_prod  = p;
        in_last  = last;
        for (int i = 0; i < 50 && !took; i++) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
        end
        checks++;
        if (!took) begin
            failures++;
            $display("FAIL send_accept: got in_ready=0 for 50 cycles, required acceptance");
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic chk_res(input string name, input logic [63:0] sum, input int cnt,
                           input logic ovf, input logic trunc);
        chk({name, "_valid"}, 64'(out_valid), 64'd1);
        chk({name, "_sum"}, out_sum, sum);
        chk({name, "_cnt"}, 64'(out_cnt), 64'(cnt));
        chk({name, "_ovf"}, 64'(out_ovf), 64'(ovf));
        chk({name, "_trunc"}, 64'(out_trunc), 64'(trunc));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk("por_valid", 64'(out_valid), 64'd0);
        chk("por_sum", out_sum, 64'd0);
        chk("por_cnt", 64'(out_cnt), 64'd0);
        chk("por_flags", 64'({out_ovf, out_trunc}), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 64'(in_ready), 64'd1);
        step();

        // Single-term burst, result held under backpressure.
        send(64'd5, 1'b1);
        chk_res("single", 64'd5, 1, 1'b0, 1'b0);
        chk("single_ready_low", 64'(in_ready), 64'd0);
        step();
        step();
        chk("single_still_held", 64'(out_valid), 64'd1);
        drain();
        chk("single_retired", 64'(out_valid), 64'd0);

        // Signed burst of four.
        send(64'd100, 1'b0);
        send(-64'sd250, 1'b0);
        send(64'd7, 1'b0);
        chk("burst4_not_early", 64'(out_valid), 64'd0);
        send(-64'sd3, 1'b1);
        chk_res("burst4", 64'hFFFF_FFFF_FFFF_FF6E, 4, 1'b0, 1'b0);
        drain();

        // Saturation both ways, and a transient excursion that comes back.
        send(64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
        send(64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
        chk_res("sat_pos", 64'h7FFF_FFFF_FFFF_FFFF, 2, 1'b1, 1'b0);
        drain();
        send(64'h8000_0000_0000_0000, 1'b0);
        send(64'h8000_0000_0000_0000, 1'b1);
        chk_res("sat_neg", 64'h8000_0000_0000_0000, 2, 1'b1, 1'b0);
        drain();
        send(64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
        send(64'd1, 1'b0);
        send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        chk_res("guard_return", 64'h7FFF_FFFF_FFFF_FFFF, 3, 1'b0, 1'b0);
        drain();

        // Truncation at MAX_TERMS.
        for (int i = 0; i < MAX_TERMS; i++) send(64'd1, 1'b0);
        chk_res("trunc", 64'd256, 256, 1'b0, 1'b1);

        // Next term offered under backpressure is refused, then retires the
        // result and starts a new burst in the same cycle.
        in_valid = 1'b1;
        in_prod  = 64'd9;
        in_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_ready_low", 64'(in_ready), 64'd0);
            step();
        end
        chk("stall_held_sum", out_sum, 64'd256);
        out_ready = 1'b1;
        @(negedge clk);
        chk("b2b_ready", 64'(in_ready), 64'd1);
        step();
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        chk_res("b2b", 64'd9, 1, 1'b0, 1'b0);
        drain();

        // clr mid-burst drops partial sum and refuses the offered term.
        send(64'd10, 1'b0);
        send(64'd20, 1'b0);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_prod  = 64'd77;
        in_last  = 1'b1;
        @(negedge clk);
        chk("clr_ready_low", 64'(in_ready), 64'd0);
        step();
        clr      = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("clr_no_valid", 64'(out_valid), 64'd0);
        step();
        chk("clr_no_valid2", 64'(out_valid), 64'd0);
        send(64'd3, 1'b1);
        chk_res("after_clr", 64'd3, 1, 1'b0, 1'b0);
        drain();

        // Asynchronous reset mid-burst, asserted between clock edges.
        send(64'd10, 1'b0);
        send(64'd20, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_sum", out_sum, 64'd0);
        chk("arst_cnt", 64'(out_cnt), 64'd0);
        chk("arst_valid", 64'(out_valid), 64'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        send(64'd3, 1'b1);
        chk_res("after_arst", 64'd3, 1, 1'b0, 1'b0);
        drain();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
